// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit_pkg                                                      |
// | Shared opcode constants, FSM encoding and helpers for muldiv_unit.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_unit_pkg;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_MUL    = 3'b000;
    localparam funct3_t F3_MULH   = 3'b001;
    localparam funct3_t F3_MULHSU = 3'b010;
    localparam funct3_t F3_MULHU  = 3'b011;
    localparam funct3_t F3_DIV    = 3'b100;
    localparam funct3_t F3_DIVU   = 3'b101;
    localparam funct3_t F3_REM    = 3'b110;
    localparam funct3_t F3_REMU   = 3'b111;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [31:0] neg_if(input logic en, input logic [31:0] v);
        return en ? (32'd0 - v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit_if                                                       |
// | Request/response bundle between the EX stage and muldiv_unit.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic        start;
    funct3_t     funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result
    );

endinterface
`default_nettype wire

// File: rtl/muldiv_unit_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step                                                             |
// | One combinational restoring shift-subtract division iteration.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;

    // Partial remainder can reach 2*divisor-1, so the trial subtract needs 33 bits.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    assign o_quo   = {i_quo[30:0], ~w_diff[32]};
    assign o_rem   = w_diff[32] ? w_shift[31:0] : w_diff[31:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_unit                                                          |
// | Iterative RV32M multiply/divide unit with busy/done handshake.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    state_t      r_state;
    state_t      w_state_nxt;
    funct3_t     r_f3;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [5:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_res_we;
    logic [31:0] w_res_nxt;

    // Multiply: 33x33 signed product of extended operands, low 64 bits kept.
    logic        w_mul_sa;
    logic        w_mul_sb;
    logic [32:0] w_a_ext;
    logic [32:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;

    assign w_mul_sa  = (r_f3 == F3_MULH) || (r_f3 == F3_MULHSU);
    assign w_mul_sb  = (r_f3 == F3_MULH);
    assign w_a_ext   = {w_mul_sa & r_a[31], r_a};
    assign w_b_ext   = {w_mul_sb & r_b[31], r_b};
    assign w_prod    = {{31{w_a_ext[32]}}, w_a_ext} * {{31{w_b_ext[32]}}, w_b_ext};
    assign w_mul_res = (r_f3 == F3_MUL) ? w_prod[31:0] : w_prod[63:32];

    // Divide: magnitudes in, signs restored on the last iteration.
    logic        w_div_signed;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_step_rem_in;
    logic [31:0] w_step_quo_in;
    logic [31:0] w_step_rem;
    logic [31:0] w_step_quo;
    logic [31:0] w_q_fin;
    logic [31:0] w_r_fin;
    logic [31:0] w_div_res;
    logic [31:0] w_spec_res;

    assign w_div_signed  = ~r_f3[0];
    assign w_div0        = (r_b == 32'd0);
    assign w_ovf         = w_div_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
    assign w_abs_a       = neg_if(w_div_signed & r_a[31], r_a);
    assign w_abs_b       = neg_if(w_div_signed & r_b[31], r_b);
    assign w_step_rem_in = (r_cnt == 6'd0) ? 32'd0   : r_rem;
    assign w_step_quo_in = (r_cnt == 6'd0) ? w_abs_a : r_quo;

    div_step u_div_step (
        .i_rem     (w_step_rem_in),
        .i_quo     (w_step_quo_in),
        .i_divisor (w_abs_b),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    assign w_q_fin    = neg_if(w_div_signed & (r_a[31] ^ r_b[31]), w_step_quo);
    assign w_r_fin    = neg_if(w_div_signed & r_a[31], w_step_rem);
    assign w_div_res  = r_f3[1] ? w_r_fin : w_q_fin;
    assign w_spec_res = w_div0 ? (r_f3[1] ? r_a   : 32'hFFFF_FFFF)
                               : (r_f3[1] ? 32'd0 : 32'h8000_0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_res_we    = 1'b0;
        w_res_nxt   = r_result;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = bus.funct3[2] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_res_we    = 1'b1;
                    w_res_nxt   = w_mul_res;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DIV: begin
                if (bus.flush) begin
                    w_state_nxt = ST_IDLE;
                end else if ((r_cnt == 6'd0) && (w_div0 || w_ovf)) begin
                    w_res_we    = 1'b1;
                    w_res_nxt   = w_spec_res;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == 6'(DIV_ITERS - 1)) begin
                    w_res_we    = 1'b1;
                    w_res_nxt   = w_div_res;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f3     <= F3_MUL;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_cnt    <= 6'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_f3  <= bus.funct3;
                r_a   <= bus.op_a;
                r_b   <= bus.op_b;
                r_cnt <= 6'd0;
            end
            if (r_state == ST_DIV) begin
                r_rem <= w_step_rem;
                r_quo <= w_step_quo;
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_res_we) begin
                r_result <= w_res_nxt;
            end
        end
    end

    assign bus.busy   = (r_state != ST_IDLE);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_unit                                                       |
// | Vector, directed and random checks of muldiv_unit against a model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_unit;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [31:0] last_exp;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain RV32M arithmetic on 64-bit integers.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 2;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    // Issue one op, scramble the inputs after acceptance, wait for done.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat,
                         output logic [2:0] flags, output logic [31:0] held);
        logic busy_ok;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        tick();
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        lat        = 1;
        busy_ok    = 1'b1;
        while (bus.done !== 1'b1 && lat < 60) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        res = bus.result;
        tick();
        flags = {busy_ok, bus.busy, bus.done};
        held  = bus.result;
    endtask

    task automatic check_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [31:0] held;
        logic [2:0]  flags;
        int          lat;
        do_op(f3, a, b, res, lat, flags, held);
        check({name, " result"}, res, exp);
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy/done"}, 32'(flags), 32'b100);
        check({name, " hold"}, held, exp);
        last_exp = exp;
    endtask

    initial begin
        logic        saw;
        int          lat;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] held;
        logic [2:0]  flags;
        int          sel;

        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 33};
        vecs[7]  = '{3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 2};
        vecs[8]  = '{3'd7, 32'd100,        32'd0,         32'h0000_0064, 2};
        vecs[9]  = '{3'd4, 32'd100,        32'd0,         32'hFFFF_FFFF, 2};
        vecs[10] = '{3'd6, 32'd100,        32'd0,         32'h0000_0064, 2};
        vecs[11] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[12] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[13] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[14] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[15] = '{3'd4, 32'h8000_0000,  32'd1,         32'h8000_0000, 33};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);

        for (int i = 0; i < 16; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                     vecs[i].exp, vecs[i].lat);
        end

        // Flush at N+10 of a DIV: idle at N+11, no done, result untouched.
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        tick();
        bus.start = 1'b0;
        saw = 1'b0;
        repeat (9) begin
            if (bus.done) saw = 1'b1;
            tick();
        end
        bus.flush = 1'b1;
        if (bus.done) saw = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush busy", 32'(bus.busy), 32'd0);
        check("flush done", 32'({saw, bus.done}), 32'd0);
        check("flush result", bus.result, last_exp);
        check_op("after flush", 3'd4, 32'd1000, 32'd7, 32'd142, 33);

        // start pulse at N+5 while busy must be ignored.
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
        tick();
        bus.start = 1'b0;
        lat = 6;
        while (bus.done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        check("ignored start latency", 32'(lat), 32'd33);
        check("ignored start result", bus.result, 32'd142);
        tick();
        check("ignored start idle1", 32'(bus.busy), 32'd0);
        tick();
        check("ignored start idle2", 32'(bus.busy), 32'd0);

        // rst at N+20 of a DIV.
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop rst busy", 32'(bus.busy), 32'd0);
        check("midop rst done", 32'(bus.done), 32'd0);
        check("midop rst result", bus.result, 32'd0);
        last_exp = 32'd0;

        // flush together with start in IDLE: nothing accepted.
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd2; bus.op_b = 32'd3;
        tick();
        bus.start = 1'b0; bus.flush = 1'b0;
        check("idle flush busy", 32'(bus.busy), 32'd0);
        tick();
        check("idle flush done", 32'({bus.busy, bus.done}), 32'd0);
        check("idle flush result", bus.result, last_exp);

        // flush in DONE: done still visible that cycle.
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd6; bus.op_b = 32'd7;
        tick();
        bus.start = 1'b0;
        tick();
        bus.flush = 1'b1;
        #1;
        check("done flush done", 32'(bus.done), 32'd1);
        check("done flush result", bus.result, 32'd42);
        tick();
        bus.flush = 1'b0;
        check("done flush after", 32'({bus.busy, bus.done}), 32'd0);
        last_exp = 32'd42;

        for (int i = 0; i < 150; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 20));
            if (sel == 3) b = -32'($urandom_range(1, 20));
            do_op(f3, a, b, res, lat, flags, held);
            check($sformatf("rand%0d f3=%0d a=%h b=%h result", i, f3, a, b), res, ref_res(f3, a, b));
            check($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(f3, a, b)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
